// File: rtl/serial_det_pkg.sv
// Shared types and limits for the serial pattern detector.
// State encoding, PAT_W bounds and default widths.
package serial_det_pkg;

    typedef logic [0:0] state_t;

    localparam state_t FILL = 1'b0;
    localparam state_t HUNT = 1'b1;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int PAT_W_DEF = 3;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/serial_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear coincident with an increment loads 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    assign sat = &cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            unique case (1'b1)
                clr:         cnt <= inc ? W'(1) : '0;
                inc && !sat: cnt <= cnt + 1'b1;
                default:     cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial detector for a runtime-programmable PAT_W-bit pattern.
// Optional saturating match counter under PATTERN_COUNT_EN.
module serial_pattern_detector
    import serial_det_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = {PAT_W{1'b1}},
    parameter int               CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             overlap_en,
`ifdef PATTERN_COUNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt,
`endif
    output logic             match,
    output logic             armed
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("PAT_W out of range");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] hist;
    logic [FW-1:0]    fill;
    state_t           state;

    logic [PAT_W-1:0] win;
    logic [FW-1:0]    fill_inc;
    logic             acc;
    logic             full;
    logic             hit;

    assign acc      = in_valid && !cfg_we;
    assign win      = {hist[PAT_W-2:0], in};
    assign fill_inc = fill + 1'b1;
    // Window counts as full when the accepted bit completes the fill.
    assign full     = (state == HUNT) || (fill_inc == FULL);
    assign hit      = acc && full && (win == pat);
    assign armed    = (state == HUNT);

    logic [FW-1:0] fill_nx;
    state_t        state_nx;

    always_comb begin
        fill_nx  = fill;
        state_nx = state;
        unique case (1'b1)
            cfg_we: begin
                fill_nx  = '0;
                state_nx = FILL;
            end
            hit && overlap_en: begin
                fill_nx  = FULL;
                state_nx = HUNT;
            end
            hit && !overlap_en: begin
                fill_nx  = '0;
                state_nx = FILL;
            end
            acc && !hit && state == FILL: begin
                fill_nx  = fill_inc;
                state_nx = (fill_inc == FULL) ? HUNT : FILL;
            end
            default: begin
                fill_nx  = fill;
                state_nx = state;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat   <= PAT_RST;
            hist  <= '0;
            fill  <= '0;
            state <= FILL;
            match <= 1'b0;
        end else begin
            fill  <= fill_nx;
            state <= state_nx;
            match <= hit;
            if (cfg_we) begin
                pat <= cfg_pattern;
            end
            if (acc) begin
                hist <= win;
            end
        end
    end

`ifdef PATTERN_COUNT_EN
    logic cnt_sat;
    logic cnt_inc;

    assign cnt_inc = hit && (cnt_clr || !cnt_sat);

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .cnt (cnt),
        .sat (cnt_sat)
    );
`endif

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: bit-queue model plus literal checks.
// Counter checks are active when PATTERN_COUNT_EN is defined.
module tb_serial_pattern_detector;

    localparam int PW = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in = 1'b0;
    logic          cfg_we = 1'b0;
    logic [PW-1:0] cfg_pattern = '0;
    logic          overlap_en = 1'b1;
    logic          cnt_clr = 1'b0;
    logic          match;
    logic          armed;
`ifdef PATTERN_COUNT_EN
    logic [CW-1:0] cnt;
`endif

    always #5 clk = ~clk;

    serial_pattern_detector #(
        .PAT_W   (PW),
        .PAT_RST (3'b111),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in          (in),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .overlap_en  (overlap_en),
`ifdef PATTERN_COUNT_EN
        .cnt_clr     (cnt_clr),
        .cnt         (cnt),
`endif
        .match       (match),
        .armed       (armed)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: accepted bits since the last restart, newest at the back.
    bit            q[$];
    logic [PW-1:0] mpat;
    logic          exp_match;
    logic          exp_armed;
    int            exp_cnt;
    bit            chk_en = 1'b0;

    function automatic bit tail_hit();
        logic [PW-1:0] w;
        if (q.size() < PW) return 1'b0;
        for (int i = 0; i < PW; i++) w[i] = q[q.size() - 1 - i];
        return w == mpat;
    endfunction

    task automatic model_reset();
        q.delete();
        mpat      = '1;
        exp_match = 1'b0;
        exp_armed = 1'b0;
        exp_cnt   = 0;
    endtask

    task automatic model_edge();
        bit hit;
        hit = 1'b0;
        if (cfg_we) begin
            mpat = cfg_pattern;
            q.delete();
        end else if (in_valid) begin
            q.push_back(in);
            hit = tail_hit();
            if (hit && !overlap_en) q.delete();
            while (q.size() > PW) void'(q.pop_front());
        end
        exp_match = hit;
        exp_armed = q.size() >= PW;
        if (cnt_clr) exp_cnt = hit ? 1 : 0;
        else if (hit && exp_cnt < (1 << CW) - 1) exp_cnt++;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("match", {31'd0, match}, {31'd0, exp_match});
            chk("armed", {31'd0, armed}, {31'd0, exp_armed});
`ifdef PATTERN_COUNT_EN
            chk("cnt", {30'd0, cnt}, exp_cnt);
`endif
        end
    end

    task automatic step(input logic v, input logic b);
        in_valid = v;
        in = b;
        @(posedge clk);
        if (rst) model_edge();
        #1;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic load(input logic [PW-1:0] p, input logic clr);
        cfg_we = 1'b1;
        cfg_pattern = p;
        cnt_clr = clr;
        step(1'b0, 1'b0);
    endtask

    task automatic bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, v[i]);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #2 chk_en = 1'b1;
        step(1'b0, 1'b0);
        chk("reset match", {31'd0, match}, 32'd0);
        chk("reset armed", {31'd0, armed}, 32'd0);
        step(1'b0, 1'b0);
        rst = 1'b1;

        // Reset pattern 111
        overlap_en = 1'b1;
        bits(8'b011, 2);
        chk("111 pre armed", {31'd0, armed}, 32'd0);
        step(1'b1, 1'b1);
        chk("111 match", {31'd0, match}, 32'd1);
        chk("111 armed", {31'd0, armed}, 32'd1);
`ifdef PATTERN_COUNT_EN
        chk("111 cnt", {30'd0, cnt}, 32'd1);
`endif
        step(1'b0, 1'b0);
        chk("idle match", {31'd0, match}, 32'd0);

        // Pattern 110 then non-matching tails
        load(3'b110, 1'b0);
        bits(8'b110, 3);
        chk("110 match", {31'd0, match}, 32'd1);
        bits(8'b10, 2);
        chk("110 tail10", {31'd0, match}, 32'd0);
        bits(8'b00, 2);
        chk("110 tail00", {31'd0, match}, 32'd0);

        // 101 overlapping
        load(3'b101, 1'b1);
        bits(8'b1010, 4);
        step(1'b1, 1'b1);
        chk("101 ovl 2nd match", {31'd0, match}, 32'd1);
`ifdef PATTERN_COUNT_EN
        chk("101 ovl cnt", {30'd0, cnt}, 32'd2);
`endif

        // 101 non-overlapping
        overlap_en = 1'b0;
        load(3'b101, 1'b0);
        bits(8'b101, 3);
        chk("101 novl match", {31'd0, match}, 32'd1);
        bits(8'b01, 2);
        chk("101 novl bit5 match", {31'd0, match}, 32'd0);
        chk("101 novl bit5 armed", {31'd0, armed}, 32'd0);
        step(1'b1, 1'b0);
        chk("101 novl bit6 armed", {31'd0, armed}, 32'd1);
        overlap_en = 1'b1;

        // Reset mid-stream drops history and restores 111
        load(3'b110, 1'b0);
        bits(8'b11, 2);
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst armed", {31'd0, armed}, 32'd0);
        step(1'b0, 1'b0);
        rst = 1'b1;
        load(3'b110, 1'b0);
        step(1'b1, 1'b0);
        chk("stale prefix", {31'd0, match}, 32'd0);
        bits(8'b11, 2);
        chk("post-rst 011", {31'd0, match}, 32'd0);
        step(1'b1, 1'b0);
        chk("post-rst match", {31'd0, match}, 32'd1);

        // cfg_we wins over the final pattern bit
        load(3'b110, 1'b0);
        bits(8'b11, 2);
        cfg_we = 1'b1;
        cfg_pattern = 3'b110;
        step(1'b1, 1'b0);
        chk("cfg prio match", {31'd0, match}, 32'd0);
        chk("cfg prio armed", {31'd0, armed}, 32'd0);
        chk("cfg prio fill", 32'(dut.fill), 32'd0);

        // Saturation and clear-with-match
        load(3'b111, 1'b1);
        bits(8'h7f, 7);
`ifdef PATTERN_COUNT_EN
        chk("sat cnt", {30'd0, cnt}, 32'd3);
`endif
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        chk("clr+match match", {31'd0, match}, 32'd1);
`ifdef PATTERN_COUNT_EN
        chk("clr+match cnt", {30'd0, cnt}, 32'd1);
`endif
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_pattern_detector.md
# serial_pattern_detector

Parameterised serial bit-pattern detector that scans a 1-bit input stream for a runtime-programmable PAT_W-bit pattern and flags each occurrence. It supports overlapping and non-overlapping match modes and, optionally, keeps a saturating match count. It sits directly behind a serial input pin or deserialiser in the test-scenario FSM area and replaces fixed-pattern, hard-coded sequence FSMs.

## Interface
- PAT_W, 3, pattern length in bits (2..16)
- PAT_RST, {PAT_W{1'b1}}, pattern register value after reset
- CNT_W, 8, match counter width (used only with PATTERN_COUNT_EN)
- clk  in  1  rising-edge clock
- rst  in  1  reset: asynchronous assertion, active-low (0 = reset)
- in_valid  in  1  qualifies `in` this cycle
- in  in  1  serial data bit
- cfg_we  in  1  load new pattern
- cfg_pattern  in  PAT_W  new pattern; MSB is the first bit in time
- overlap_en  in  1  1 = overlapping matches, 0 = non-overlapping
- match  out  1  one-cycle pulse per detected pattern
- armed  out  1  window holds PAT_W valid bits (state HUNT)
- cnt  out  CNT_W  saturating match count (PATTERN_COUNT_EN only)
- cnt_clr  in  1  synchronous counter clear (PATTERN_COUNT_EN only)

## Operation
- Registers:
  - pattern register `pat`
  - history shift register `hist`, PAT_W bits; a new bit enters at the LSB
  - fill counter `fill`, 0..PAT_W
  - state
- States:
  - FILL: fewer than PAT_W bits collected.
  - HUNT: window full; compare on every accepted bit.
- Accepted bit (in_valid=1, cfg_we=0):
  - hist <= {hist[PAT_W-2:0], in}.
  - In FILL: fill increments; on reaching PAT_W, go to HUNT.
- Match condition: the post-shift window (including the accepted bit) equals `pat`, and the window is full. This covers the bit that completes the fill.
- On match:
  - overlap_en=1: stay in or enter HUNT; history is kept.
  - overlap_en=0: fill <= 0, go to FILL. The next match needs PAT_W fresh bits.
- cfg_we=1:
  - pat <= cfg_pattern, fill <= 0, state <= FILL, no match.
  - Any in_valid bit in the same cycle is discarded (cfg_we has priority).
- in_valid=0: all state holds; match=0.
- overlap_en is sampled only at the clock edge where a match occurs.

## Timing
- Reset values: match=0, armed=0, cnt=0, hist=0, fill=0, state=FILL, pat=PAT_RST.
- Latency: match is registered and rises in the cycle after the edge that samples the final pattern bit. It lasts exactly one cycle.
- Back-to-back matches on consecutive accepted bits are legal, e.g. pattern 111 with overlap and a stream of 1s gives match in consecutive cycles.
- armed is registered and mirrors state==HUNT.
- Reset mid-stream drops all partial history immediately. The first match after reset requires PAT_W new bits.
- Counter:
  - cnt increments on each match and saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr and match in the same cycle give cnt=1.

## Configuration
- PATTERN_COUNT_EN:
  - Defined: the cnt/cnt_clr ports and the CNT_W counter exist, behaving as specified above.
  - Undefined: the ports and counter are absent and the remaining behaviour is unchanged.

## Structure
- The shared package `serial_det_pkg` holds:
  - the state typedef (FILL, HUNT)
  - the PAT_W minimum and maximum limit constants
  - the default PAT_W and CNT_W constants
- The top level holds the FSM, pat, hist, fill and output registers.
- One sub-module, `sat_counter` (width parameter; inc, clr, sat), is instantiated only under PATTERN_COUNT_EN.

## Test plan
- Reset with PAT_W=3, PAT_RST=111; drive 1,1,1 (valid) -> armed after the 3rd bit; match pulses one cycle after the 3rd bit; cnt=1.
- cfg_we with pattern 110; drive 1,1,0 -> match after the 3rd bit; then drive 1,0 -> no match; 0,0 -> no match.
- Pattern 101, overlap_en=1; stream 1,0,1,0,1 -> match after bits 3 and 5; cnt=2.
- Pattern 101, overlap_en=0; same stream -> match only after bit 3; armed drops after that match and rises after bit 6.
- Assert rst low after bits 1,1 of pattern 110, release, then drive 0,1,1,0 -> single match after the final 0; pat returns to 111 at reset, so reload 110 first; verify no match on a stale prefix.
- Assert cfg_we on the same edge as a valid final pattern bit -> no match, fill=0; with CNT_W=2, force 4 matches -> cnt holds at 3; cnt_clr coincident with a match -> cnt=1.
